// File: rtl/clk_div_cfg_pkg.sv
// clk_div_cfg_pkg: shared divider width macro, controller state encodings and sizing helper.
`ifndef CLK_DIV_CFG_MACROS
`define CLK_DIV_CFG_MACROS
`define CLK_DIV_WIDTH 8
`endif

package clk_div_cfg_pkg;
    localparam int CLK_DIV_WIDTH = `CLK_DIV_WIDTH;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_LOCK   = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Wide enough to hold ratio*lock_periods-1 without overflow.
    function automatic int lock_cnt_width(input int dw, input int lp);
        return dw + $clog2(lp) + 1;
    endfunction
endpackage

// File: rtl/clk_div_cfg_ctrl_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter; pointer flips away from the winner on each update strobe.
module rr_arbiter2 (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req,
    input  logic       i_update,
    output logic       o_valid,
    output logic       o_gnt
);
    logic ptr_q;

    assign o_valid = |i_req;
    assign o_gnt   = &i_req ? ptr_q : i_req[1];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) ptr_q <= 1'b0;
        else if (i_update) ptr_q <= ~o_gnt;
    end
endmodule

// File: rtl/clk_div_cfg_ctrl.sv
// clk_div_cfg_ctrl: arbitrates divider ratio changes and sequences disable/settle/load/enable/lock.
module clk_div_cfg_ctrl
    import clk_div_cfg_pkg::*;
#(
    parameter int DIV_WIDTH     = CLK_DIV_WIDTH,
    parameter int SETTLE_CYCLES = 4,
    parameter int LOCK_PERIODS  = 2,
    parameter int RESET_RATIO   = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_req0,
    input  logic                 i_req1,
    input  logic [DIV_WIDTH-1:0] i_ratio0,
    input  logic [DIV_WIDTH-1:0] i_ratio1,
    output logic                 o_ack0,
    output logic                 o_ack1,
    output logic                 o_nack0,
    output logic                 o_nack1,
    output logic [DIV_WIDTH-1:0] o_div_ratio,
    output logic                 o_clk_en,
    output logic                 o_busy,
    output logic                 o_locked
);
    localparam int CW = lock_cnt_width(DIV_WIDTH, LOCK_PERIODS);

    logic [1:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] lat_q, lat_d, ratio_q, ratio_d;
    logic                 gid_q, gid_d;
    logic                 clk_en_q, clk_en_d, locked_q, locked_d, busy_q, busy_d;
    logic [1:0]           ack_q, ack_d, nack_q, nack_d;
    logic                 arb_valid, arb_gnt;
    logic [DIV_WIDTH-1:0] gnt_ratio;

    rr_arbiter2 u_arb (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_req    ({i_req1, i_req0}),
        .i_update (state_q == ST_IDLE && arb_valid),
        .o_valid  (arb_valid),
        .o_gnt    (arb_gnt)
    );

    assign gnt_ratio = arb_gnt ? i_ratio1 : i_ratio0;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lat_d    = lat_q;
        gid_d    = gid_q;
        ratio_d  = ratio_q;
        clk_en_d = clk_en_q;
        locked_d = locked_q;
        ack_d    = '0;
        nack_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    if (gnt_ratio < DIV_WIDTH'(2)) begin
                        nack_d[arb_gnt] = 1'b1;
                    end else if (gnt_ratio == ratio_q && locked_q) begin
                        ack_d[arb_gnt] = 1'b1;
                    end else begin
                        lat_d    = gnt_ratio;
                        gid_d    = arb_gnt;
                        clk_en_d = 1'b0;
                        locked_d = 1'b0;
                        cnt_d    = CW'(SETTLE_CYCLES - 1);
                        state_d  = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    ratio_d  = lat_q;
                    clk_en_d = 1'b1;
                    cnt_d    = CW'(lat_q) * CW'(LOCK_PERIODS) - CW'(1);
                    state_d  = ST_LOCK;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_LOCK: begin
                // Ack and lock are registered on entry so they coincide with the DONE cycle.
                if (cnt_q == '0) begin
                    ack_d[gid_q] = 1'b1;
                    locked_d     = 1'b1;
                    state_d      = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = state_d != ST_IDLE;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            lat_q    <= '0;
            gid_q    <= 1'b0;
            ratio_q  <= DIV_WIDTH'(RESET_RATIO);
            clk_en_q <= 1'b0;
            locked_q <= 1'b0;
            busy_q   <= 1'b0;
            ack_q    <= '0;
            nack_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lat_q    <= lat_d;
            gid_q    <= gid_d;
            ratio_q  <= ratio_d;
            clk_en_q <= clk_en_d;
            locked_q <= locked_d;
            busy_q   <= busy_d;
            ack_q    <= ack_d;
            nack_q   <= nack_d;
        end
    end

    assign o_ack0      = ack_q[0];
    assign o_ack1      = ack_q[1];
    assign o_nack0     = nack_q[0];
    assign o_nack1     = nack_q[1];
    assign o_div_ratio = ratio_q;
    assign o_clk_en    = clk_en_q;
    assign o_busy      = busy_q;
    assign o_locked    = locked_q;
endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// tb_clk_div_cfg_ctrl: table-driven, hand-written and random checks against a timeline reference model.
module tb_clk_div_cfg_ctrl;
    localparam int S = 4;
    localparam int L = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [7:0] ratio0 = '0, ratio1 = '0;
    logic       ack0, ack1, nack0, nack1, clk_en, busy, locked;
    logic [7:0] div_ratio;

    always #5 clk = ~clk;

    clk_div_cfg_ctrl #(
        .DIV_WIDTH     (8),
        .SETTLE_CYCLES (S),
        .LOCK_PERIODS  (L),
        .RESET_RATIO   (1)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req0      (req0),
        .i_req1      (req1),
        .i_ratio0    (ratio0),
        .i_ratio1    (ratio1),
        .o_ack0      (ack0),
        .o_ack1      (ack1),
        .o_nack0     (nack0),
        .o_nack1     (nack1),
        .o_div_ratio (div_ratio),
        .o_clk_en    (clk_en),
        .o_busy      (busy),
        .o_locked    (locked)
    );

    int checks = 0, failures = 0, cyc = 0;

    // Reference model: a granted sequence is a timeline anchored at its grant cycle.
    bit       m_active, m_ptr;
    int       m_t, m_done, m_gid, m_new;
    int       e_ratio;
    bit       e_clk_en, e_locked, e_busy;
    bit [1:0] e_ack, e_nack, p_ack, p_nack;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic cmp_all();
        chk("clk_en", clk_en, e_clk_en);
        chk("busy", busy, e_busy);
        chk("locked", locked, e_locked);
        chk("div_ratio", div_ratio, e_ratio);
        chk("ack0", ack0, e_ack[0]);
        chk("ack1", ack1, e_ack[1]);
        chk("nack0", nack0, e_nack[0]);
        chk("nack1", nack1, e_nack[1]);
    endtask

    task automatic decide();
        int r[2];
        int g;
        r[0] = ratio0;
        r[1] = ratio1;
        if (m_active || rst || !(req0 || req1)) return;
        g = (req0 && req1) ? int'(m_ptr) : (req1 ? 1 : 0);
        m_ptr = (g == 0);
        if (r[g] < 2) p_nack[g] = 1'b1;
        else if (r[g] == e_ratio && e_locked) p_ack[g] = 1'b1;
        else begin
            m_active = 1'b1;
            m_t      = cyc;
            m_done   = cyc + S + r[g] * L + 1;
            m_gid    = g;
            m_new    = r[g];
        end
    endtask

    task automatic step();
        decide();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        e_ack  = p_ack;
        e_nack = p_nack;
        p_ack  = '0;
        p_nack = '0;
        if (m_active) begin
            if (cyc == m_t + 1) begin e_busy = 1; e_clk_en = 0; e_locked = 0; end
            if (cyc == m_t + S + 1) begin e_ratio = m_new; e_clk_en = 1; end
            if (cyc == m_done) begin e_ack[m_gid] = 1'b1; e_locked = 1; end
            if (cyc == m_done + 1) begin e_busy = 0; m_active = 0; end
        end
        cmp_all();
        if (e_ack[0] || e_nack[0]) req0 = 1'b0;
        if (e_ack[1] || e_nack[1]) req1 = 1'b0;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        #1;
        m_active = 0; m_ptr = 0; e_ratio = 1; e_clk_en = 0; e_locked = 0; e_busy = 0;
        e_ack = '0; e_nack = '0; p_ack = '0; p_nack = '0;
        cmp_all();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [7:0] pick();
        int v;
        v = $urandom_range(0, 9);
        return 8'(v == 0 ? 0 : v == 1 ? 1 : v == 2 ? e_ratio : $urandom_range(2, 10));
    endfunction

    typedef struct {
        bit r0, r1;
        int ra0, ra1;
        int lat0, lat1;
        bit nak0, nak1;
        int ratio;
        bit busy;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int got0, got1, acks, lat;
        bit k0, k1, bz;
        tbl[0] = '{1, 0, 8, 0, 21, 0, 0, 0, 8, 1};
        tbl[1] = '{0, 1, 0, 8, 0, 1, 0, 0, 8, 0};
        tbl[2] = '{1, 0, 1, 0, 1, 0, 1, 0, 8, 0};
        tbl[3] = '{0, 1, 0, 0, 0, 1, 0, 1, 8, 0};
        tbl[4] = '{1, 1, 4, 6, 13, 31, 0, 0, 6, 1};
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            got0 = 0; got1 = 0; k0 = 0; k1 = 0; bz = 0;
            req0 = tbl[i].r0; ratio0 = 8'(tbl[i].ra0);
            req1 = tbl[i].r1; ratio1 = 8'(tbl[i].ra1);
            for (int k = 1; k <= 60 && !((!tbl[i].r0 || got0 != 0) && (!tbl[i].r1 || got1 != 0)); k++) begin
                step();
                bz |= busy;
                if (got0 == 0 && (ack0 || nack0)) begin got0 = k; k0 = nack0; end
                if (got1 == 0 && (ack1 || nack1)) begin got1 = k; k1 = nack1; end
            end
            if (tbl[i].r0) begin chk("vec_lat0", got0, tbl[i].lat0); chk("vec_kind0", k0, tbl[i].nak0); end
            if (tbl[i].r1) begin chk("vec_lat1", got1, tbl[i].lat1); chk("vec_kind1", k1, tbl[i].nak1); end
            chk("vec_ratio", div_ratio, tbl[i].ratio);
            chk("vec_busy_seen", bz, tbl[i].busy);
            repeat (2) step();
        end

        // Reset while in LOCK aborts the sequence with no ack.
        req0 = 1'b1; ratio0 = 8'd5;
        repeat (S + 3) step();
        chk("pre_reset_busy", busy, 1);
        do_reset();
        acks = 0;
        repeat (25) begin
            step();
            acks += int'(ack0) + int'(ack1);
        end
        chk("no_ack_after_reset", acks, 0);

        // Requester drops req during SETTLE; ack still arrives on schedule.
        req1 = 1'b1; ratio1 = 8'd3;
        repeat (2) step();
        req1 = 1'b0;
        lat = 0;
        for (int k = 3; k <= 40 && lat == 0; k++) begin
            step();
            if (ack1) lat = k;
        end
        chk("drop_ack_lat", lat, S + 3 * L + 1);
        chk("drop_ratio", div_ratio, 3);
        repeat (2) step();

        repeat (2500) begin
            if (!req0 && !(m_active && m_gid == 0) && $urandom_range(0, 3) == 0) begin
                ratio0 = pick(); req0 = 1'b1;
            end
            if (!req1 && !(m_active && m_gid == 1) && $urandom_range(0, 3) == 0) begin
                ratio1 = pick(); req1 = 1'b1;
            end
            if (m_active && cyc > m_t && cyc < m_done && $urandom_range(0, 15) == 0) begin
                if (m_gid == 0) req0 = 1'b0;
                else req1 = 1'b0;
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
